// File: rtl/rc4_pkg.sv
// rc4_pkg: shared RC4 key-schedule defaults, FSM state encoding and index-width helper
package rc4_pkg;
  localparam int DEF_RAM_WIDTH  = 8;
  localparam int DEF_KEY_LENGTH = 3;
  typedef enum logic [3:0] {
    IDLE, RD_I, WT_I, CALC_J, RD_J, WT_J, WR_I, WR_J, NEXT, DONE
  } ksa_state_e;
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/key_byte_select.sv
// key_byte_select: combinational pick of key byte idx (byte 0 = MSB byte); in secret_key, idx; out key_byte
module key_byte_select
  import rc4_pkg::*;
#(
  parameter int KEY_LENGTH = DEF_KEY_LENGTH,
  parameter int IW         = idx_width(KEY_LENGTH)
) (
  input  logic [KEY_LENGTH*8-1:0] secret_key,
  input  logic [IW-1:0]           idx,
  output logic [7:0]              key_byte
);
  always_comb begin
    key_byte = '0;
    for (int n = 0; n < KEY_LENGTH; n++)
      if (idx == IW'(n)) key_byte = secret_key[(KEY_LENGTH-1-n)*8 +: 8];
  end
endmodule

// File: rtl/key_scheduler.sv
// key_scheduler: RC4 KSA over a synchronous S-array RAM; in clk, reset_n, enable, secret_key, ram_q; out address, ram_in, write_enable, done
module key_scheduler
  import rc4_pkg::*;
#(
  parameter int RAM_WIDTH  = DEF_RAM_WIDTH,
  parameter int KEY_LENGTH = DEF_KEY_LENGTH
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [KEY_LENGTH*8-1:0] secret_key,
  input  logic [RAM_WIDTH-1:0]    ram_q,
  output logic [RAM_WIDTH-1:0]    address,
  output logic [RAM_WIDTH-1:0]    ram_in,
  output logic                    write_enable,
  output logic                    done
);
  localparam int IW = idx_width(KEY_LENGTH);
  ksa_state_e state_q, state_d;
  logic [RAM_WIDTH-1:0] i_q, i_d, j_q, j_d, si_q, si_d;
  logic [RAM_WIDTH-1:0] address_q, address_d, ram_in_q, ram_in_d;
  logic                 write_enable_q, write_enable_d, done_q, done_d;
  logic [IW-1:0]        k_q, k_d;
  logic [7:0]           key_byte;
  key_byte_select #(.KEY_LENGTH(KEY_LENGTH), .IW(IW)) u_key_byte_select (
    .secret_key(secret_key),
    .idx       (k_q),
    .key_byte  (key_byte)
  );
  // Outputs are registered from the next state, so each state's outputs are
  // stable for its whole cycle. ram_in_q doubles as the sj latch: it captures
  // S[j] from ram_q on the WT_J->WR_I edge and drives it during WR_I.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    si_d    = si_q;
    if (!enable) begin
      state_d = IDLE;
      i_d     = '0;
      j_d     = '0;
      k_d     = '0;
    end else begin
      case (state_q)
        IDLE:   state_d = RD_I;
        RD_I:   state_d = WT_I;
        WT_I:   state_d = CALC_J;
        CALC_J: begin
          si_d    = ram_q;
          j_d     = j_q + ram_q + RAM_WIDTH'(key_byte);
          state_d = RD_J;
        end
        RD_J:   state_d = WT_J;
        WT_J:   state_d = WR_I;
        WR_I:   state_d = WR_J;
        WR_J:   state_d = NEXT;
        NEXT: begin
          if (&i_q) state_d = DONE;
          else begin
            i_d     = i_q + RAM_WIDTH'(1);
            k_d     = (k_q == IW'(KEY_LENGTH-1)) ? '0 : k_q + IW'(1);
            state_d = RD_I;
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
    address_d      = (state_d inside {RD_I, WT_I, CALC_J, WR_I}) ? i_d :
                     (state_d inside {RD_J, WT_J, WR_J}) ? j_d : '0;
    ram_in_d       = (state_d == WR_I) ? ram_q : (state_d == WR_J) ? si_q : '0;
    write_enable_d = state_d inside {WR_I, WR_J};
    done_d         = state_d == DONE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      i_q            <= '0;
      j_q            <= '0;
      k_q            <= '0;
      si_q           <= '0;
      address_q      <= '0;
      ram_in_q       <= '0;
      write_enable_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      i_q            <= i_d;
      j_q            <= j_d;
      k_q            <= k_d;
      si_q           <= si_d;
      address_q      <= address_d;
      ram_in_q       <= ram_in_d;
      write_enable_q <= write_enable_d;
      done_q         <= done_d;
    end
  end
  assign address      = address_q;
  assign ram_in       = ram_in_q;
  assign write_enable = write_enable_q;
  assign done         = done_q;
endmodule
